timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 32, count/period width in bits.
- PSC_W, 8, prescaler width in bits.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  system clock (25 MHz board crystal).
- rst  in  1  synchronous, active-high reset.
- cfg_wr  in  1  configuration write strobe.
- cfg_period  in  WIDTH  terminal count P.
- cfg_prescale  in  PSC_W  prescale value S; count advances every S+1 cycles.
- cfg_oneshot  in  1  1 = one-shot mode, 0 = periodic mode.
- start  in  1  start-request pulse.
- stop  in  1  stop-request pulse.
- count  out  WIDTH  current count value.
- running  out  1  high while in RUN.
- done  out  1  high while in DONE.
- tick  out  1  one-cycle pulse on each terminal-count wrap.

REQ-003 The single clock SHALL be clk; all state SHALL update on the rising edge of clk only.

REQ-004 Reset SHALL be synchronous and active-high on rst; rst SHALL take priority over every other input.

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, RUN and DONE; running = (state==RUN); done = (state==DONE).

REQ-006 Configuration registers (period_r, psc_r, oneshot_r) SHALL load from the cfg_* inputs on cfg_wr only in IDLE or DONE.
- cfg_wr in RUN SHALL be ignored.

REQ-007 Transitions:
- start in IDLE or DONE -> RUN; count and the prescaler SHALL clear to 0 on the same edge.
- stop in RUN -> IDLE; count SHALL hold its value.

REQ-008 When start and stop are asserted in the same cycle, stop SHALL win:
- In RUN -> IDLE.
- In IDLE or DONE -> no state change.

REQ-009 When cfg_wr and start are asserted in the same cycle in IDLE or DONE, the new configuration SHALL take effect for that run.

REQ-010 Prescaler psc (PSC_W bits) in RUN:
- If psc == psc_r: psc <= 0 and enable en = 1 in that cycle.
- Otherwise: psc <= psc + 1.
- With S = 0, en SHALL be high every RUN cycle.

REQ-011 Counting on en in RUN:
- If count == period_r: count <= 0 and tick SHALL be 1 in the following cycle.
- Otherwise: count <= count + 1 (modulo 2^WIDTH, no carry out).

REQ-012 tick SHALL be a registered, exactly one-cycle pulse; it SHALL never assert outside the cycle following a wrap.

REQ-013 On a wrap with oneshot_r = 1, the FSM SHALL enter DONE on the same edge. In DONE:
- count SHALL hold 0.
- done SHALL stay high until start or rst.

REQ-014 On a wrap with oneshot_r = 0, the FSM SHALL stay in RUN. The tick period SHALL be exactly (P+1)*(S+1) cycles.

REQ-015 P = 0 SHALL produce a wrap on every en, giving a tick every S+1 cycles in periodic mode.

REQ-016 Latency: start sampled at edge N gives running = 1 and count = 0 after edge N. With S = 0, count = 1 after edge N+1.

REQ-017 In IDLE and DONE, psc and count SHALL not advance.

Reset
REQ-018 On rst the block SHALL set:
- state = IDLE.
- count = 0, psc = 0.
- tick = 0, running = 0, done = 0.
- period_r = 0, psc_r = 0, oneshot_r = 0.

REQ-019 rst asserted mid-run SHALL abort the run with no tick in the following cycle.

REQ-020 The first cycle after rst deasserts SHALL accept cfg_wr and start.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Periodic, P = 3, S = 0, start at cycle 0 -> count 0,1,2,3,0,...; tick at cycles 5, 9, 13; running stays 1.
- One-shot, P = 2, S = 1 -> count advances every 2 cycles; a single tick; done = 1 with count = 0 afterward; no further ticks.
- start and stop in the same cycle while RUN with count = 5 -> IDLE, count holds 5, no tick.
- cfg_wr with P = 9 during RUN (period_r = 3) -> ignored, wrap still at 3; after stop, cfg_wr plus start -> wrap at 9.
- rst asserted on the same cycle as a wrap -> no tick afterward, all outputs at reset values.
- P = 0, S = 4, periodic -> tick every 5 cycles, count stays 0.

Source files
------------

// File: rtl/timer_ctrl.sv
// Programmable timer with a prescaler and periodic or one-shot mode.
// A registered tick pulses for one cycle in the cycle after each terminal-count wrap.
module timer_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned PSC_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_wr,
   input  logic [WIDTH-1:0] cfg_period,
   input  logic [PSC_W-1:0] cfg_prescale,
   input  logic             cfg_oneshot,
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             done,
   output logic             tick
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_count;
   logic [PSC_W-1:0]   r_psc;
   logic               r_tick;
   logic [WIDTH-1:0]   r_period;
   logic [PSC_W-1:0]   r_psc_val;
   logic               r_oneshot;

   state_t             w_state_d;
   logic [WIDTH-1:0]   w_count_d;
   logic [PSC_W-1:0]   w_psc_d;
   logic               w_tick_d;
   logic               w_cfg_ld;
   logic               w_en;

   always_comb begin
      w_state_d = r_state;
      w_count_d = r_count;
      w_psc_d   = r_psc;
      w_tick_d  = 1'b0;
      w_cfg_ld  = 1'b0;
      w_en      = 1'b0;
      unique case (r_state)
         StIdle, StDone: begin
            w_cfg_ld = cfg_wr;
            // stop beats start even when not running
            if (start && !stop) begin
               w_state_d = StRun;
               w_count_d = '0;
               w_psc_d   = '0;
            end
         end
         StRun: begin
            if (stop) begin
               w_state_d = StIdle;
            end else begin
               w_en    = (r_psc == r_psc_val);
               w_psc_d = w_en ? '0 : r_psc + 1'b1;
               if (w_en) begin
                  if (r_count == r_period) begin
                     w_count_d = '0;
                     w_tick_d  = 1'b1;
                     if (r_oneshot) w_state_d = StDone;
                  end else begin
                     w_count_d = r_count + 1'b1;
                  end
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= StIdle;
         r_count   <= '0;
         r_psc     <= '0;
         r_tick    <= 1'b0;
         r_period  <= '0;
         r_psc_val <= '0;
         r_oneshot <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_count <= w_count_d;
         r_psc   <= w_psc_d;
         r_tick  <= w_tick_d;
         // Loading on the start edge makes the new configuration apply to that run
         if (w_cfg_ld) begin
            r_period  <= cfg_period;
            r_psc_val <= cfg_prescale;
            r_oneshot <= cfg_oneshot;
         end
      end
   end

   assign count   = r_count;
   assign running = (r_state == StRun);
   assign done    = (r_state == StDone);
   assign tick    = r_tick;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: vector table, directed corner sequences,
// then random stimulus against an elapsed-time reference model.
module tb_timer_ctrl;

   logic        clk = 1'b0;
   logic        rst, cfg_wr, cfg_oneshot, start, stop;
   logic [31:0] cfg_period;
   logic [7:0]  cfg_prescale;
   logic [31:0] count;
   logic        running, done, tick;

   int n_checks = 0;
   int n_fail   = 0;

   timer_ctrl #(.WIDTH(32), .PSC_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_wr       (cfg_wr),
      .cfg_period   (cfg_period),
      .cfg_prescale (cfg_prescale),
      .cfg_oneshot  (cfg_oneshot),
      .start        (start),
      .stop         (stop),
      .count        (count),
      .running      (running),
      .done         (done),
      .tick         (tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, cw;
      logic [31:0] per;
      logic [7:0]  psc;
      logic        os, st, sp;
      logic [31:0] e_cnt;
      logic        e_run, e_done, e_tick;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic cw, logic [31:0] p, logic [7:0] s, logic os,
                               logic st, logic sp, logic [31:0] ec, logic er, logic ed,
                               logic et);
      vec_t v;
      v.rst = r; v.cw = cw; v.per = p; v.psc = s; v.os = os; v.st = st; v.sp = sp;
      v.e_cnt = ec; v.e_run = er; v.e_done = ed; v.e_tick = et;
      return v;
   endfunction

   task automatic drive(logic r, logic cw, logic [31:0] p, logic [7:0] s, logic os,
                        logic st, logic sp);
      rst = r; cfg_wr = cw; cfg_period = p; cfg_prescale = s; cfg_oneshot = os;
      start = st; stop = sp;
   endtask

   task automatic chk(string nm, logic [31:0] ec, logic er, logic ed, logic et);
      n_checks++;
      if (count !== ec || running !== er || done !== ed || tick !== et) begin
         n_fail++;
         $display("FAIL %s: got count=%0d running=%b done=%b tick=%b, expected count=%0d running=%b done=%b tick=%b",
                  nm, count, running, done, tick, ec, er, ed, et);
      end
   endtask

   task automatic step_chk(string nm, logic [31:0] ec, logic er, logic ed, logic et);
      @(posedge clk);
      #1;
      chk(nm, ec, er, ed, et);
   endtask

   // Reference model: counts RUN edges since start and derives count/tick arithmetically
   typedef enum int {MIdle, MRun, MDone} mmode_t;
   mmode_t      m_mode;
   longint      m_e;
   logic [31:0] m_hold;
   longint      m_p, m_s;
   logic        m_os, m_tick;

   function automatic logic [31:0] m_count();
      if (m_mode == MRun)  return 32'((m_e / (m_s + 1)) % (m_p + 1));
      if (m_mode == MIdle) return m_hold;
      return 32'd0;
   endfunction

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0);

      // Periodic P=3 S=0, cfg_wr ignored in RUN, stop holds count
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 3, 0, 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 1, 9, 0, 0, 0, 0, 2, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].cw, tbl[i].per, tbl[i].psc, tbl[i].os, tbl[i].st, tbl[i].sp);
         step_chk($sformatf("table[%0d]", i), tbl[i].e_cnt, tbl[i].e_run, tbl[i].e_done,
                  tbl[i].e_tick);
      end

      // New period applied with cfg_wr+start; then start+stop at count 5
      drive(0, 1, 9, 0, 0, 1, 0);
      step_chk("p9_start", 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 9; k++) step_chk($sformatf("p9_cnt%0d", k), k, 1, 0, 0);
      step_chk("p9_wrap", 0, 1, 0, 1);
      for (int k = 1; k <= 5; k++) step_chk($sformatf("p9_again%0d", k), k, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 1);
      step_chk("startstop_run", 5, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      step_chk("startstop_hold", 5, 0, 0, 0);

      // One-shot P=2 S=1
      drive(0, 1, 2, 1, 1, 1, 0);
      step_chk("os_start", 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      step_chk("os_e1", 0, 1, 0, 0);
      step_chk("os_e2", 1, 1, 0, 0);
      step_chk("os_e3", 1, 1, 0, 0);
      step_chk("os_e4", 2, 1, 0, 0);
      step_chk("os_e5", 2, 1, 0, 0);
      step_chk("os_wrap", 0, 0, 1, 1);
      for (int k = 0; k < 6; k++) step_chk($sformatf("os_done%0d", k), 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 1, 1);
      step_chk("startstop_done", 0, 0, 1, 0);

      // Reset on the wrap edge, then immediate cfg_wr+start
      drive(0, 1, 1, 0, 0, 1, 0);
      step_chk("rw_start", 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      step_chk("rw_e1", 1, 1, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      step_chk("rst_on_wrap", 0, 0, 0, 0);
      drive(0, 1, 0, 4, 0, 1, 0);
      step_chk("post_rst_start", 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 15; k++)
         step_chk($sformatf("p0s4_e%0d", k), 0, 1, 0, (k % 5) == 0);
      drive(0, 0, 0, 0, 0, 0, 1);
      step_chk("p0s4_stop", 0, 0, 0, 0);

      // Reset clears config: start alone runs with P=0 S=0
      drive(1, 0, 0, 0, 0, 0, 0);
      step_chk("rst_cfg", 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 0);
      step_chk("rst_cfg_start", 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) step_chk($sformatf("rst_cfg_tick%0d", k), 0, 1, 0, 1);

      // Random phase
      drive(1, 0, 0, 0, 0, 0, 0);
      step_chk("rand_rst", 0, 0, 0, 0);
      m_mode = MIdle; m_e = 0; m_hold = 0; m_p = 0; m_s = 0; m_os = 0;
      for (int i = 0; i < 3000; i++) begin
         logic r, cw, os, st, sp;
         logic [31:0] p;
         logic [7:0]  s;
         r  = ($urandom_range(63, 0) == 0);
         cw = ($urandom_range(7, 0) == 0);
         st = ($urandom_range(9, 0) == 0);
         sp = ($urandom_range(24, 0) == 0);
         os = $urandom_range(1, 0) == 1;
         p  = $urandom_range(7, 0);
         s  = 8'($urandom_range(3, 0));
         drive(r, cw, p, s, os, st, sp);
         m_tick = 1'b0;
         if (r) begin
            m_mode = MIdle; m_e = 0; m_hold = 0; m_p = 0; m_s = 0; m_os = 0;
         end else if (m_mode == MRun) begin
            if (sp) begin
               m_hold = m_count();
               m_mode = MIdle;
            end else begin
               m_e++;
               if ((m_e % (m_s + 1)) == 0 && ((m_e / (m_s + 1)) % (m_p + 1)) == 0) begin
                  m_tick = 1'b1;
                  if (m_os) m_mode = MDone;
               end
            end
         end else begin
            if (cw) begin
               m_p = longint'(p); m_s = longint'(s); m_os = os;
            end
            if (st && !sp) begin
               m_mode = MRun;
               m_e = 0;
            end
         end
         step_chk($sformatf("rand[%0d]", i), m_count(), m_mode == MRun, m_mode == MDone,
                  m_tick);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
